ann_predict_sequencer: RTL and testbench
========================================

// Module: ann_predict_sequencer
// PURPOSE
//  Controller that runs the full-year Tmin predictor around the ANN core, one prediction per day.
//  Per day: streams WEIGHT_NUM weights into the ANN, presents a 4-day temperature window and fires
//  the ANN. It then captures Data_out, scales the result by /1000 and slides the window.
//  Missing or zero next-day samples are replaced by the day's own prediction (autoregressive fill).
// PARAMETERS
//  DATA_W     156  bus width of temperatures/weights (13*12)
//  INPUT_NUM  4    window depth (fixed to 4 ANN temperature ports)
//  WEIGHT_NUM 40   weights per day (4*8 + 8)
//  SETTLE     10   idle cycles between last weight and fire
//  FIRE_CYC   5    cycles ann_rev_ready is held high
//  TIMEOUT    255  max WAIT cycles for ann_ready
//  DAYS       365  predictions per run
// PORTS
//  Clk          in  1      clock, rising edge
//  Reset_l      in  1      asynchronous active-low reset
//  start        in  1      pulse: begin one day's prediction
//  hist_valid   in  1      history sample offered
//  hist_data    in  DATA_W history sample
//  hist_missing in  1      sample flagged absent (contains X/unknown upstream)
//  hist_ready   out 1      sequencer accepts history sample this cycle
//  wt_valid     in  1      weight word offered
//  wt_data      in  DATA_W weight word
//  wt_ready     out 1      weight accepted this cycle
//  ann_weight_in out DATA_W   to ANN Weight_in
//  ann_save_en   out 1        to ANN Weight_Save_enable
//  ann_load_en   out 1        to ANN Weight_Load_enable, tied 0
//  ann_train_en  out 1        to ANN training_enable_h, tied 0
//  ann_temp0..3  out DATA_W   to ANN Temperature_in_0..3 (0 = oldest)
//  ann_rev_ready out 1        to ANN tb_rev_ready_h
//  ann_data_out  in  DATA_W   from ANN Data_out
//  ann_ready     in  1        from ANN Ready_Signal
//  pred_valid   out 1      one-cycle strobe, pred_data valid
//  pred_data    out 26     ann_data_out[25:0] / 1000, unsigned, truncated
//  day_idx      out 9      index of the current/last prediction
//  busy         out 1      high in every state except IDLE
//  run_done     out 1      sticky once DAYS predictions have completed
//  err          out 1      sticky: timeout, or start with window not full
// BEHAVIOUR
//  Reset (async, Reset_l=0): state=IDLE, all outputs 0, window empty (fill_cnt=0), counters 0.
//  Window fill: while fill_cnt<INPUT_NUM, in IDLE: hist_ready=1; each hist_valid shifts sample in at
//   temp3, older entries move toward temp0, fill_cnt++.
//  FSM IDLE->LOAD_W->SETTLE->FIRE->WAIT->DIV->NEXT->IDLE.
//  IDLE: start && fill_cnt==4 && !run_done -> LOAD_W. With window not full: err=1, stay IDLE.
//   start ignored when busy or run_done.
//  LOAD_W: wt_ready=1. Each wt_valid&&wt_ready cycle: ann_weight_in=wt_data, ann_save_en=1 in
//   that same cycle, w_cnt++. At w_cnt==WEIGHT_NUM go to SETTLE. Stalls (wt_valid=0) drive save_en=0.
//  SETTLE: count SETTLE cycles, then FIRE.
//  FIRE: ann_rev_ready=1 for exactly FIRE_CYC cycles, then WAIT.
//  WAIT: on the first cycle ann_ready==1, latch ann_data_out[25:0] -> DIV. After TIMEOUT cycles with
//   no ann_ready: err=1, no pred_valid, go to IDLE. day_idx is not advanced; the window is unchanged.
//  DIV: iterative restoring divide by 1000, 1 quotient bit per cycle, 26 cycles. Then pred_data
//   is updated and pred_valid=1 for 1 cycle.
//  NEXT: hist_ready=1. Wait for hist_valid, then shift the window once. The new temp3 = hist_data,
//   except if hist_missing or hist_data==0: temp3 = {zero-extended pred_data}.
//   day_idx++. If day_idx reaches DAYS: run_done=1. Then go to IDLE.
//  Latency start->pred_valid = WEIGHT_NUM + SETTLE + FIRE_CYC + (WAIT cycles) + 26 + 1, with
//   no weight stalls.
//  ann_temp0..3 change only on a window shift, so they are stable throughout LOAD_W..DIV.
//  Async reset mid-day aborts at once. The ANN sees save_en=0 and rev_ready=0, and the window is lost.
// TESTING
//  1 Reset: Reset_l=0 while in FIRE -> all outputs 0 in the same cycle, state IDLE, fill_cnt=0.
//  2 Nominal: fill 4 samples, start, 40 weights back-to-back, ANN model returns 26'd12345678
//   after 3 cycles. Required: 40 save_en pulses in order, rev_ready high for 5 cycles,
//   pred_data=12345, and day_idx 0->1.
//  3 Autoregressive fill: in NEXT, hist_data=0 -> temp3=prediction. hist_missing=1 with
//   nonzero data -> temp3=prediction. Normal sample -> temp3=hist_data.
//  4 Timeout: ann_ready held 0 -> err=1 after 255 WAIT cycles, no pred_valid, IDLE, window unchanged.
//  5 Weight stalls/start misuse: wt_valid toggling -> exactly 40 save_en pulses. Start with
//   fill_cnt=2 -> err=1. Start while busy -> ignored.
//  6 Full run: DAYS=3 -> run_done=1 after the 3rd NEXT; a further start is ignored.

Source files
------------

// File: rtl/ann_predict_sequencer.sv
// Day-by-day controller for the Tmin ANN: loads weights, fires the core, divides the
// result by 1000 and slides a 4-deep temperature window with autoregressive fill.
module ann_predict_sequencer #(
    parameter int DATA_W     = 156,
    parameter int INPUT_NUM  = 4,
    parameter int WEIGHT_NUM = 40,
    parameter int SETTLE     = 10,
    parameter int FIRE_CYC   = 5,
    parameter int TIMEOUT    = 255,
    parameter int DAYS       = 365
) (
    input  logic              Clk,
    input  logic              Reset_l,
    input  logic              start,
    input  logic              hist_valid,
    input  logic [DATA_W-1:0] hist_data,
    input  logic              hist_missing,
    output logic              hist_ready,
    input  logic              wt_valid,
    input  logic [DATA_W-1:0] wt_data,
    output logic              wt_ready,
    output logic [DATA_W-1:0] ann_weight_in,
    output logic              ann_save_en,
    output logic              ann_load_en,
    output logic              ann_train_en,
    output logic [DATA_W-1:0] ann_temp0,
    output logic [DATA_W-1:0] ann_temp1,
    output logic [DATA_W-1:0] ann_temp2,
    output logic [DATA_W-1:0] ann_temp3,
    output logic              ann_rev_ready,
    input  logic [DATA_W-1:0] ann_data_out,
    input  logic              ann_ready,
    output logic              pred_valid,
    output logic [25:0]       pred_data,
    output logic [8:0]        day_idx,
    output logic              busy,
    output logic              run_done,
    output logic              err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_W = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_FIRE   = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_DIV    = 3'd5;
    localparam logic [2:0] S_NEXT   = 3'd6;

    logic [2:0]  state_reg;
    logic [7:0]  cnt_reg;
    logic [2:0]  fill_cnt_reg;
    logic [9:0]  rem_reg;
    logic [25:0] quo_reg;
    logic [25:0] pred_data_reg;
    logic        pred_valid_reg;
    logic [8:0]  day_idx_reg;
    logic        run_done_reg;
    logic        err_reg;

    logic              window_full;
    logic              wt_accept;
    logic              shift_en;
    logic [DATA_W-1:0] shift_data;
    logic [DATA_W-1:0] win [0:3];
    logic [DATA_W-1:0] win_in [0:3];

    logic [10:0] div_shift;
    logic [10:0] div_diff;
    logic        div_ge;
    logic [9:0]  rem_next;
    logic [25:0] quo_next;
    logic        unused_ann_bits;

    assign unused_ann_bits = ^ann_data_out[DATA_W-1:26];

    assign window_full = (fill_cnt_reg == 3'(INPUT_NUM));
    assign wt_accept   = (state_reg == S_LOAD_W) && wt_valid;
    // Gating with Reset_l keeps every output low while reset is held.
    assign hist_ready  = Reset_l && (((state_reg == S_IDLE) && !window_full) || (state_reg == S_NEXT));
    assign shift_en    = hist_valid && hist_ready;

    always_comb begin
        shift_data = hist_data;
        if ((state_reg == S_NEXT) && (hist_missing || (hist_data == '0)))
            shift_data = {{(DATA_W-26){1'b0}}, pred_data_reg};
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_win
            logic [DATA_W-1:0] tap_reg;
            if (gi == 3) begin : g_head
                assign win_in[gi] = shift_data;
            end else begin : g_body
                assign win_in[gi] = win[gi+1];
            end
            always_ff @(posedge Clk or negedge Reset_l) begin
                if (!Reset_l)
                    tap_reg <= '0;
                else if (shift_en)
                    tap_reg <= win_in[gi];
            end
            assign win[gi] = tap_reg;
        end
    endgenerate

    // Restoring divide step: the sign of (partial remainder - 1000) gives the quotient bit.
    always_comb begin
        div_shift = {rem_reg, quo_reg[25]};
        div_diff  = div_shift - 11'd1000;
        div_ge    = ~div_diff[10];
        rem_next  = div_ge ? div_diff[9:0] : div_shift[9:0];
        quo_next  = {quo_reg[24:0], div_ge};
    end

    always_ff @(posedge Clk or negedge Reset_l) begin
        if (!Reset_l) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            fill_cnt_reg   <= '0;
            rem_reg        <= '0;
            quo_reg        <= '0;
            pred_data_reg  <= '0;
            pred_valid_reg <= 1'b0;
            day_idx_reg    <= '0;
            run_done_reg   <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            pred_valid_reg <= 1'b0;
            if (shift_en && (state_reg == S_IDLE))
                fill_cnt_reg <= fill_cnt_reg + 3'd1;
            case (state_reg)
                S_IDLE: begin
                    if (start && !run_done_reg) begin
                        if (window_full) begin
                            state_reg <= S_LOAD_W;
                            cnt_reg   <= '0;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                S_LOAD_W: begin
                    if (wt_accept) begin
                        if (cnt_reg == 8'(WEIGHT_NUM-1)) begin
                            state_reg <= S_SETTLE;
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 8'd1;
                        end
                    end
                end
                S_SETTLE: begin
                    if (cnt_reg == 8'(SETTLE-1)) begin
                        state_reg <= S_FIRE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                S_FIRE: begin
                    if (cnt_reg == 8'(FIRE_CYC-1)) begin
                        state_reg <= S_WAIT;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                S_WAIT: begin
                    if (ann_ready) begin
                        quo_reg   <= ann_data_out[25:0];
                        rem_reg   <= '0;
                        cnt_reg   <= '0;
                        state_reg <= S_DIV;
                    end else if (cnt_reg == 8'(TIMEOUT-1)) begin
                        err_reg   <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= S_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                S_DIV: begin
                    quo_reg <= quo_next;
                    rem_reg <= rem_next;
                    if (cnt_reg == 8'd25) begin
                        pred_data_reg  <= quo_next;
                        pred_valid_reg <= 1'b1;
                        cnt_reg        <= '0;
                        state_reg      <= S_NEXT;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                S_NEXT: begin
                    if (hist_valid) begin
                        day_idx_reg <= day_idx_reg + 9'd1;
                        if (day_idx_reg == 9'(DAYS-1))
                            run_done_reg <= 1'b1;
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign wt_ready      = (state_reg == S_LOAD_W);
    assign ann_save_en   = wt_accept;
    assign ann_weight_in = wt_accept ? wt_data : '0;
    assign ann_load_en   = 1'b0;
    assign ann_train_en  = 1'b0;
    assign ann_rev_ready = (state_reg == S_FIRE);
    assign ann_temp0     = win[0];
    assign ann_temp1     = win[1];
    assign ann_temp2     = win[2];
    assign ann_temp3     = win[3];
    assign pred_valid    = pred_valid_reg;
    assign pred_data     = pred_data_reg;
    assign day_idx       = day_idx_reg;
    assign busy          = (state_reg != S_IDLE);
    assign run_done      = run_done_reg;
    assign err           = err_reg;

endmodule

// File: tb/tb_ann_predict_sequencer.sv
// Directed/randomized bench for ann_predict_sequencer with a behavioural ANN and window model.
module tb_ann_predict_sequencer;

    logic         Clk;
    logic         Reset_l;
    logic         start;
    logic         hist_valid;
    logic [155:0] hist_data;
    logic         hist_missing;
    logic         hist_ready;
    logic         wt_valid;
    logic [155:0] wt_data;
    logic         wt_ready;
    logic [155:0] ann_weight_in;
    logic         ann_save_en;
    logic         ann_load_en;
    logic         ann_train_en;
    logic [155:0] ann_temp0, ann_temp1, ann_temp2, ann_temp3;
    logic         ann_rev_ready;
    logic [155:0] ann_data_out;
    logic         ann_ready;
    logic         pred_valid;
    logic [25:0]  pred_data;
    logic [8:0]   day_idx;
    logic         busy;
    logic         run_done;
    logic         err;

    ann_predict_sequencer #(.DAYS(3)) dut (
        .Clk(Clk), .Reset_l(Reset_l), .start(start),
        .hist_valid(hist_valid), .hist_data(hist_data), .hist_missing(hist_missing),
        .hist_ready(hist_ready), .wt_valid(wt_valid), .wt_data(wt_data), .wt_ready(wt_ready),
        .ann_weight_in(ann_weight_in), .ann_save_en(ann_save_en), .ann_load_en(ann_load_en),
        .ann_train_en(ann_train_en), .ann_temp0(ann_temp0), .ann_temp1(ann_temp1),
        .ann_temp2(ann_temp2), .ann_temp3(ann_temp3), .ann_rev_ready(ann_rev_ready),
        .ann_data_out(ann_data_out), .ann_ready(ann_ready), .pred_valid(pred_valid),
        .pred_data(pred_data), .day_idx(day_idx), .busy(busy), .run_done(run_done), .err(err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [155:0] obs, input logic [155:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [155:0] rnd156();
        logic [155:0] r = '0;
        for (int i = 0; i < 5; i++) r = {r[123:0], $urandom()};
        return r;
    endfunction

    // Observation of the ANN-facing side, sampled mid-cycle.
    logic [155:0] wq[$];
    int           rev_cnt, pv_cnt, busy_cnt;
    logic [25:0]  pv_data;
    always @(negedge Clk) begin
        if (ann_save_en) wq.push_back(ann_weight_in);
        if (ann_rev_ready) rev_cnt++;
        if (pred_valid) begin
            pv_cnt++;
            pv_data = pred_data;
        end
        if (busy) busy_cnt++;
    end

    // ANN core model: answers ann_delay cycles after rev_ready drops; ann_delay<=0 never answers.
    int           ann_delay;
    logic [155:0] ann_value;
    int           ann_cnt;
    bit           armed;
    always @(negedge Clk) begin
        if (!Reset_l) begin
            armed        = 1'b0;
            ann_ready    = 1'b0;
            ann_data_out = '0;
        end else begin
            ann_ready = 1'b0;
            if (ann_rev_ready) begin
                armed   = 1'b1;
                ann_cnt = 0;
            end else if (armed) begin
                ann_cnt++;
                if (ann_delay > 0 && ann_cnt == ann_delay) begin
                    ann_ready    = 1'b1;
                    ann_data_out = ann_value;
                    armed        = 1'b0;
                end
            end
        end
    end

    // Reference window: index 0 oldest, 3 newest.
    logic [155:0] mwin [4];

    task automatic mshift(input logic [155:0] v);
        mwin[0] = mwin[1];
        mwin[1] = mwin[2];
        mwin[2] = mwin[3];
        mwin[3] = v;
    endtask

    task automatic check_win(input string tag);
        check({tag, "_temp0"}, ann_temp0, mwin[0]);
        check({tag, "_temp1"}, ann_temp1, mwin[1]);
        check({tag, "_temp2"}, ann_temp2, mwin[2]);
        check({tag, "_temp3"}, ann_temp3, mwin[3]);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset_l = 1'b0; start = 1'b0; hist_valid = 1'b0; hist_data = '0; hist_missing = 1'b0;
        wt_valid = 1'b0; wt_data = '0; ann_delay = 0; ann_value = '0;
        for (int i = 0; i < 4; i++) mwin[i] = '0;
        step(); step();
        Reset_l = 1'b1;
        step();
    endtask

    task automatic fill(input logic [155:0] v);
        check("fill_ready", hist_ready, 1'b1);
        hist_valid = 1'b1; hist_data = v; hist_missing = 1'b0;
        step();
        hist_valid = 1'b0;
        mshift(v);
        $display("[TB] fill sample %0h", v[31:0]);
    endtask

    task automatic run_day(input bit stall, input int delay, input logic [25:0] val,
                           input bit poke_start, output bit got);
        logic [155:0] ew[$];
        int sent, guard, bad;
        bit acc;
        ew = {};
        for (int i = 0; i < 40; i++) ew.push_back(rnd156());
        wq = {}; rev_cnt = 0; pv_cnt = 0; busy_cnt = 0;
        ann_delay = delay;
        ann_value = rnd156();
        ann_value[25:0] = val;
        start = 1'b1;
        step();
        start = 1'b0;
        sent = 0; guard = 0;
        while (sent < 40 && guard < 400) begin
            wt_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            wt_data  = ew[sent];
            acc = wt_valid && wt_ready;
            step();
            if (acc) sent++;
            guard++;
        end
        wt_valid = 1'b0;
        check("weights_sent", sent, 40);
        guard = 0;
        while (pv_cnt == 0 && busy && guard < 1000) begin
            if (poke_start && guard == 20) start = 1'b1;
            step();
            start = 1'b0;
            guard++;
        end
        check("day_bounded", (guard < 1000), 1'b1);
        check("save_count", wq.size(), 40);
        bad = 0;
        for (int i = 0; i < 40; i++)
            if (i >= wq.size() || wq[i] !== ew[i]) bad++;
        check("weight_order", bad, 0);
        check("rev_cycles", rev_cnt, 5);
        got = (pv_cnt > 0);
    endtask

    task automatic next_day(input logic [155:0] v, input bit missing, input logic [25:0] pred);
        check("next_ready", hist_ready, 1'b1);
        hist_valid = 1'b1; hist_data = v; hist_missing = missing;
        step();
        hist_valid = 1'b0; hist_missing = 1'b0;
        mshift((missing || v == '0) ? {130'b0, pred} : v);
    endtask

    initial begin
        bit got;
        logic [25:0] val, exp_pred;
        int guard;

        do_reset();
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_run_done", run_done, 1'b0);
        check("rst_day_idx", day_idx, 9'd0);
        check("rst_hist_ready", hist_ready, 1'b1);
        check_win("rst");

        // Start with only two samples present must flag err and stay idle.
        fill(rnd156() | 156'd1);
        fill(rnd156() | 156'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("early_start_err", err, 1'b1);
        check("early_start_busy", busy, 1'b0);
        $display("[TB] start with window not full");
        do_reset();

        for (int i = 0; i < 4; i++) fill(rnd156() | 156'd1);
        check_win("filled");
        check("filled_hist_ready", hist_ready, 1'b0);

        // Day 0: nominal, fixed ANN answer, start poked while busy.
        run_day(1'b0, 3, 26'd12345678, 1'b1, got);
        check("d0_pred_seen", got, 1'b1);
        check("d0_pred", pv_data, 26'd12345);
        check("d0_day_idx_before", day_idx, 9'd0);
        check_win("d0_stable");
        begin
            logic [155:0] s = rnd156() | 156'd1;
            next_day(s, 1'b0, 26'd12345);
        end
        check("d0_day_idx_after", day_idx, 9'd1);
        check_win("d0_shift");
        step(); step(); step();
        check("d0_idle_after_poke", busy, 1'b0);
        check("d0_err", err, 1'b0);
        $display("[TB] day 0 pred=%0d", pv_data);

        // Day 1: weight stalls, random answer, zero sample -> prediction fills in.
        val = 26'($urandom());
        exp_pred = val / 26'd1000;
        run_day(1'b1, int'($urandom_range(1, 10)), val, 1'b0, got);
        check("d1_pred_seen", got, 1'b1);
        check("d1_pred", pv_data, exp_pred);
        next_day('0, 1'b0, exp_pred);
        check("d1_day_idx", day_idx, 9'd2);
        check_win("d1_zero_fill");
        $display("[TB] day 1 pred=%0d", pv_data);

        // Timeout: ANN never answers.
        run_day(1'b0, -1, 26'd0, 1'b0, got);
        check("to_no_pred", got, 1'b0);
        check("to_busy_cycles", busy_cnt, 310);
        check("to_err", err, 1'b1);
        check("to_busy", busy, 1'b0);
        check("to_day_idx", day_idx, 9'd2);
        check_win("to_window");
        $display("[TB] timeout day busy_cycles=%0d", busy_cnt);

        // Day 2: missing-flagged sample -> prediction fills in, run completes.
        val = 26'($urandom());
        exp_pred = val / 26'd1000;
        run_day(1'b1, int'($urandom_range(1, 10)), val, 1'b0, got);
        check("d2_pred_seen", got, 1'b1);
        check("d2_pred", pv_data, exp_pred);
        check("d2_run_done_before", run_done, 1'b0);
        next_day(rnd156() | 156'd1, 1'b1, exp_pred);
        check("d2_day_idx", day_idx, 9'd3);
        check("d2_run_done", run_done, 1'b1);
        check_win("d2_missing_fill");
        $display("[TB] day 2 pred=%0d", pv_data);

        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("done_start_busy", busy, 1'b0);
        check("done_start_wt_ready", wt_ready, 1'b0);
        check("done_day_idx", day_idx, 9'd3);

        // Reset in the middle of FIRE.
        do_reset();
        for (int i = 0; i < 4; i++) fill(rnd156() | 156'd1);
        ann_delay = 3;
        start = 1'b1;
        step();
        start = 1'b0;
        wt_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wt_data = rnd156();
            step();
        end
        wt_valid = 1'b0;
        guard = 0;
        while (!ann_rev_ready && guard < 100) begin
            step();
            guard++;
        end
        check("fire_reached", ann_rev_ready, 1'b1);
        Reset_l = 1'b0;
        #1;
        check("mid_rst_rev_ready", ann_rev_ready, 1'b0);
        check("mid_rst_save_en", ann_save_en, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_hist_ready", hist_ready, 1'b0);
        check("mid_rst_wt_ready", wt_ready, 1'b0);
        check("mid_rst_pred_valid", pred_valid, 1'b0);
        check("mid_rst_day_idx", day_idx, 9'd0);
        for (int i = 0; i < 4; i++) mwin[i] = '0;
        check_win("mid_rst");
        step();
        Reset_l = 1'b1;
        step();
        check("post_rst_fill_empty", hist_ready, 1'b1);
        check("post_rst_busy", busy, 1'b0);
        $display("[TB] reset during fire");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
